// File: rtl/prci_rst_seq.sv
// prci_rst_seq: multi-domain reset sequencer.
// Waits until every domain's lock/ready source is stable, then releases the
// per-domain resets one at a time with RELEASE_DLY cycles between releases.
// Lock loss re-sequences every domain. In RUN it also supports a per-domain
// soft-reset pulse and a debug reset that leaves domain 0 running.
//
// Ports:
//   i_clk          reference clock (free-running)
//   i_rst          asynchronous active-high reset
//   i_locked       per-domain lock/ready, asynchronous to i_clk
//   i_swreset      per-domain soft-reset request pulse
//   i_dmireset     debug reset request pulse (re-sequences domains 1..NDOM-1)
//   o_rst/o_nrst   per-domain reset, active-high / active-low
//   o_all_ready    every domain out of reset, in RUN, no soft reset active
//   o_lock_timeout sticky per-domain "lock never arrived" flag
//   o_state        0 = WAIT_LOCK, 1 = RELEASE, 2 = RUN
//
// state     | meaning
// ----------+----------------------------------------------------------
// WAIT_LOCK | all resets held, waiting for every filtered lock
// RELEASE   | releasing domain r_idx after RELEASE_DLY cycles each
// RUN       | all domains released; serve soft and debug resets
module prci_rst_seq #(
  parameter int NDOM        = 4,
  parameter int RELEASE_DLY = 16,
  parameter int LOCK_FILT   = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NDOM-1:0] i_locked,
  input  logic [NDOM-1:0] i_swreset,
  input  logic            i_dmireset,
  output logic [NDOM-1:0] o_rst,
  output logic [NDOM-1:0] o_nrst,
  output logic            o_all_ready,
  output logic [NDOM-1:0] o_lock_timeout,
  output logic [1:0]      o_state
);

  localparam int IW = $clog2(NDOM) + 1;
  localparam int SW = $clog2(RELEASE_DLY + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(LOCK_FILT + 1);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_REL  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [SW-1:0] DLY_LAST = SW'(RELEASE_DLY - 1);
  localparam logic [SW-1:0] DLY_LEN  = SW'(RELEASE_DLY);
  localparam logic [WW-1:0] WAIT_TO  = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);
  localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILT);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDOM - 1);

  logic [NDOM-1:0]          r_lock_m;
  logic [NDOM-1:0]          r_lock_s;
  logic [NDOM-1:0][FW-1:0]  r_filt;
  logic [NDOM-1:0]          w_lock_ok;
  logic                     w_all_lock;

  logic [1:0]               r_state,  w_state_nxt;
  logic [IW-1:0]            r_idx,    w_idx_nxt;
  logic [SW-1:0]            r_dly,    w_dly_nxt;
  logic [WW-1:0]            r_wait,   w_wait_nxt;
  logic [NDOM-1:0][SW-1:0]  r_sw,     w_sw_nxt;
  logic [NDOM-1:0]          r_rst,    w_rst_nxt;
  logic [NDOM-1:0]          r_nrst;
  logic                     r_ready,  w_ready_nxt;
  logic [NDOM-1:0]          r_to,     w_to_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lock_m <= '0;
      r_lock_s <= '0;
    end else begin
      r_lock_m <= i_locked;
      r_lock_s <= r_lock_m;
    end
  end

  // Saturating stability filter: a single low sample restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filt <= '0;
    end else begin
      for (int d = 0; d < NDOM; d++) begin
        if (!r_lock_s[d])
          r_filt[d] <= '0;
        else if (r_filt[d] != FILT_MAX)
          r_filt[d] <= r_filt[d] + FW'(1);
      end
    end
  end

  always_comb begin
    w_lock_ok = '0;
    for (int d = 0; d < NDOM; d++)
      w_lock_ok[d] = (r_filt[d] == FILT_MAX);
  end

  assign w_all_lock = &w_lock_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dly_nxt   = r_dly;
    w_wait_nxt  = r_wait;
    w_sw_nxt    = r_sw;
    w_rst_nxt   = r_rst;
    w_ready_nxt = r_ready;
    w_to_nxt    = r_to;

    // Soft-reset down-counters run in any state; terminal count drops the reset.
    for (int d = 0; d < NDOM; d++) begin
      if (r_sw[d] != '0) begin
        w_sw_nxt[d] = r_sw[d] - SW'(1);
        if (r_sw[d] == SW'(1))
          w_rst_nxt[d] = 1'b0;
      end
    end

    case (r_state)
      ST_WAIT: begin
        w_rst_nxt   = '1;
        w_ready_nxt = 1'b0;
        if (w_all_lock) begin
          w_state_nxt = ST_REL;
          w_idx_nxt   = '0;
          w_dly_nxt   = '0;
          w_wait_nxt  = '0;
        end else begin
          if (r_wait == WAIT_TO)
            w_to_nxt = r_to | ~w_lock_ok;
          if (r_wait != WAIT_MAX)
            w_wait_nxt = r_wait + WW'(1);
        end
      end

      ST_REL, ST_RUN: begin
        if (!w_all_lock) begin
          // Lock loss outranks everything and cancels soft resets.
          w_state_nxt = ST_WAIT;
          w_rst_nxt   = '1;
          w_ready_nxt = 1'b0;
          w_idx_nxt   = '0;
          w_dly_nxt   = '0;
          w_wait_nxt  = '0;
          w_sw_nxt    = '0;
        end else if (r_state == ST_REL) begin
          w_ready_nxt = 1'b0;
          if (r_dly == DLY_LAST) begin
            for (int d = 0; d < NDOM; d++)
              if (r_idx == IW'(d))
                w_rst_nxt[d] = 1'b0;
            w_dly_nxt = '0;
            w_idx_nxt = r_idx + IW'(1);
            if (r_idx == IDX_LAST)
              w_state_nxt = ST_RUN;
          end else begin
            w_dly_nxt = r_dly + SW'(1);
          end
        end else if (i_dmireset && (NDOM > 1)) begin
          // Debug reset re-sequences domains 1.. only; domain 0 keeps running,
          // including any soft reset it already has in flight.
          for (int d = 1; d < NDOM; d++) begin
            w_rst_nxt[d] = 1'b1;
            w_sw_nxt[d]  = '0;
          end
          w_state_nxt = ST_REL;
          w_idx_nxt   = IW'(1);
          w_dly_nxt   = '0;
          w_ready_nxt = 1'b0;
        end else begin
          // A repeated request simply reloads the counter.
          for (int d = 0; d < NDOM; d++) begin
            if (i_swreset[d]) begin
              w_sw_nxt[d]  = DLY_LEN;
              w_rst_nxt[d] = 1'b1;
            end
          end
          w_ready_nxt = (w_sw_nxt == '0);
        end
      end

      default: begin
        w_state_nxt = ST_WAIT;
        w_rst_nxt   = '1;
        w_ready_nxt = 1'b0;
        w_idx_nxt   = '0;
        w_dly_nxt   = '0;
        w_wait_nxt  = '0;
        w_sw_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_WAIT;
      r_idx   <= '0;
      r_dly   <= '0;
      r_wait  <= '0;
      r_sw    <= '0;
      r_rst   <= '1;
      r_nrst  <= '0;
      r_ready <= 1'b0;
      r_to    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_dly   <= w_dly_nxt;
      r_wait  <= w_wait_nxt;
      r_sw    <= w_sw_nxt;
      r_rst   <= w_rst_nxt;
      r_nrst  <= ~w_rst_nxt;
      r_ready <= w_ready_nxt;
      r_to    <= w_to_nxt;
    end
  end

  assign o_rst          = r_rst;
  assign o_nrst         = r_nrst;
  assign o_all_ready    = r_ready;
  assign o_lock_timeout = r_to;
  assign o_state        = r_state;

endmodule

// File: tb/tb_prci_rst_seq.sv
// tb_prci_rst_seq: directed bench for prci_rst_seq with default parameters
// (NDOM=4, RELEASE_DLY=16, LOCK_FILT=4, TIMEOUT=1024).
// Time base: inputs change and outputs are sampled 1 ns after a rising edge;
// "cycle k" is the interval after the k-th edge following reset release.
module tb_prci_rst_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] locked = 4'b0000;
  logic [3:0] swr = 4'b0000;
  logic       dmi = 1'b0;
  logic [3:0] o_rst, o_nrst, o_to;
  logic       o_ready;
  logic [1:0] o_state;

  int checks = 0;
  int failures = 0;
  int nrst_bad = 0;
  int tf[4];
  int tr;
  int rst0_hi;
  int k;

  prci_rst_seq dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_locked(locked),
    .i_swreset(swr),
    .i_dmireset(dmi),
    .o_rst(o_rst),
    .o_nrst(o_nrst),
    .o_all_ready(o_ready),
    .o_lock_timeout(o_to),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (o_nrst !== ~o_rst) nrst_bad++;
    end
  endtask

  // Records the tick (relative to the call) at which each o_rst bit is first
  // low and o_all_ready first high; bounded by limit ticks.
  task automatic run_seq(input int limit);
    for (int d = 0; d < 4; d++) tf[d] = -1;
    tr = -1;
    rst0_hi = 0;
    for (int i = 1; i <= limit && tr < 0; i++) begin
      tick(1);
      for (int d = 0; d < 4; d++)
        if (tf[d] < 0 && o_rst[d] === 1'b0) tf[d] = i;
      if (o_rst[0] !== 1'b0) rst0_hi = 1;
      if (o_ready === 1'b1) tr = i;
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, input string tag);
    int n = 0;
    while (o_state !== s && n < limit) begin
      tick(1);
      n++;
    end
    chk(tag, o_state, s);
  endtask

  task automatic check_spacing(input string tag);
    chk({tag, "_d1"}, tf[1] - tf[0], 16);
    chk({tag, "_d2"}, tf[2] - tf[0], 32);
    chk({tag, "_d3"}, tf[3] - tf[0], 48);
    chk({tag, "_ready"}, tr - tf[3], 1);
    chk({tag, "_state"}, o_state, 2);
  endtask

  initial begin
    // Reset values
    tick(3);
    chk("rst_o_rst", o_rst, 4'hF);
    chk("rst_o_nrst", o_nrst, 4'h0);
    chk("rst_ready", o_ready, 0);
    chk("rst_timeout", o_to, 4'h0);
    chk("rst_state", o_state, 0);

    // 1: all locks rise in cycle 0
    rst = 1'b0;
    locked = 4'hF;
    run_seq(120);
    chk("s1_fall0_window", (tf[0] >= 22 && tf[0] <= 24), 1);
    chk("s1_fall0", tf[0], 23);
    check_spacing("s1");

    // 4: debug reset spares domain 0
    dmi = 1'b1;
    tick(1);
    dmi = 1'b0;
    chk("s4_rst", o_rst, 4'b1110);
    chk("s4_state", o_state, 1);
    chk("s4_ready", o_ready, 0);
    run_seq(100);
    chk("s4_d1", tf[1], 16);
    chk("s4_d2", tf[2], 32);
    chk("s4_d3", tf[3], 48);
    chk("s4_ready_rise", tr, 49);
    chk("s4_d0_stays_low", rst0_hi, 0);

    // 5: soft reset of domain 2 at t and t+5
    swr = 4'b0100;
    tick(1);
    swr = 4'b0000;
    chk("s5_start_rst", o_rst, 4'b0100);
    chk("s5_start_ready", o_ready, 0);
    tick(4);
    swr = 4'b0100;
    tick(1);
    swr = 4'b0000;
    tick(15);
    chk("s5_t21_rst", o_rst, 4'b0100);
    chk("s5_t21_ready", o_ready, 0);
    tick(1);
    chk("s5_t22_rst", o_rst, 4'b0000);
    chk("s5_t22_ready", o_ready, 1);

    // Concurrent soft resets on domains 0 and 3, one cycle apart
    swr = 4'b0001;
    tick(1);
    swr = 4'b1000;
    tick(1);
    swr = 4'b0000;
    chk("sw2_both", o_rst, 4'b1001);
    tick(15);
    chk("sw2_d0_done", o_rst, 4'b1000);
    chk("sw2_ready_low", o_ready, 0);
    tick(1);
    chk("sw2_d3_done", o_rst, 4'b0000);
    chk("sw2_ready", o_ready, 1);

    // 3: one-cycle glitch on lock 1
    locked = 4'b1101;
    tick(1);
    locked = 4'hF;
    k = 0;
    while (o_rst !== 4'hF && k < 6) begin
      tick(1);
      k++;
    end
    chk("s3_all_rst", o_rst, 4'hF);
    chk("s3_latency", (k <= 3), 1);
    chk("s3_ready", o_ready, 0);
    chk("s3_state", o_state, 0);
    run_seq(120);
    chk("s3_fall0_window", (tf[0] >= 19 && tf[0] <= 21), 1);
    check_spacing("s3");

    // 6: lock loss, debug reset and soft reset in the same cycle
    locked = 4'b0111;
    tick(3);
    dmi = 1'b1;
    swr = 4'b0001;
    tick(1);
    dmi = 1'b0;
    swr = 4'b0000;
    chk("s6_rst", o_rst, 4'hF);
    chk("s6_state", o_state, 0);
    chk("s6_ready", o_ready, 0);
    tick(20);
    chk("s6_hold_rst", o_rst, 4'hF);
    chk("s6_hold_state", o_state, 0);

    // 2: lock 2 never arrives -> timeout flag
    rst = 1'b1;
    locked = 4'b1011;
    tick(2);
    rst = 1'b0;
    tick(1020);
    chk("s2_pre_timeout", o_to, 4'h0);
    chk("s2_pre_state", o_state, 0);
    tick(10);
    chk("s2_timeout", o_to, 4'b0100);
    chk("s2_rst_held", o_rst, 4'hF);
    locked = 4'hF;
    run_seq(120);
    check_spacing("s2");
    chk("s2_timeout_sticky", o_to, 4'b0100);

    // Asynchronous reset in the middle of RELEASE
    locked = 4'b1110;
    tick(1);
    locked = 4'hF;
    wait_state(2'd0, 8, "mid_wait");
    wait_state(2'd1, 40, "mid_release");
    tick(20);
    chk("mid_partial", o_rst, 4'b1110);
    rst = 1'b1;
    #2;
    chk("arst_o_rst", o_rst, 4'hF);
    chk("arst_o_nrst", o_nrst, 4'h0);
    chk("arst_state", o_state, 0);
    chk("arst_ready", o_ready, 0);
    chk("arst_timeout", o_to, 4'h0);

    chk("nrst_complement", nrst_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
